mem_port_arbiter: RTL and testbench

Arbitrates a single-ported unified memory between the instruction-fetch (IF) requester and the MEM-stage data requester (DM) of the 5-stage pipeline. It sequences each access through a registered request/ready handshake and returns read data with a one-cycle acknowledge. It also drives per-requester stall signals that freeze the PC, IF/ID and EX/MEM registers while an access is pending. DM normally has priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/starve_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and grant decisions.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP_IF,
    RESP_DM
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_DM
  } grant_t;

  function automatic int unsigned starve_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/starve_ctr.sv
// Saturating count of back-to-back DM grants taken while fetch was waiting.
module starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int unsigned W = starve_width(STARVE_MAX);
  localparam logic [W-1:0] MAXV = W'(STARVE_MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAXV)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == MAXV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// MEM-stage data port, with registered handshake, one-cycle acks and stall outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_ack,
  output logic [N-1:0] if_rdata,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic         dm_ack,
  output logic [N-1:0] dm_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic         if_stall,
  output logic         dm_stall
);

  arb_state_t state;
  grant_t     gnt;
  logic       sat;
  logic       cnt_clr;
  logic       cnt_inc;

  // DM wins a collision unless fetch has already been passed over STARVE_MAX times.
  always_comb begin
    gnt = GNT_NONE;
    if (state == IDLE) begin
      if (dm_req && (!if_req || !sat)) begin
        gnt = GNT_DM;
      end else if (if_req) begin
        gnt = GNT_IF;
      end
    end
  end

  assign cnt_inc = (gnt == GNT_DM) && if_req;
  assign cnt_clr = (gnt == GNT_IF) || ((gnt == GNT_DM) && !if_req);

  starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .sat  (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (gnt)
            GNT_IF: begin
              state    <= BUSY_IF;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
            GNT_DM: begin
              state     <= BUSY_DM;
              mem_req   <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end
            default: ;
          endcase
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state    <= RESP_IF;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            state   <= RESP_DM;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_ack <= 1'b1;
          end
        end
        RESP_IF, RESP_DM: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model of the arbitration, latency and data-return rules.
module tb_mem_port_arbiter;

  localparam int unsigned N    = 32;
  localparam int unsigned SMAX = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req, dm_req, dm_we, mem_ready;
  logic [N-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic         if_ack, dm_ack, mem_req, mem_we, if_stall, dm_stall;
  logic [N-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N(N),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall)
  );

  typedef enum int {PH_IDLE, PH_BUSY, PH_RESP} ph_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ph_t         ph;
  int          who;
  logic [31:0] x_addr, x_wdata, resp_data, if_hold, dm_hold;
  logic        x_we;
  int          wait_left, fixed_wait, streak;
  bit          if_pend, dm_pend, auto_on, if_rep, dm_rep;
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] grant_log [$];
  logic        prev_mem_req, obs_we;
  logic [31:0] obs_wdata;
  int          mreq_cnt, if_stall_cnt, if_ack_cyc, dm_ack_cyc, ready_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic issue_if(input logic [31:0] a);
    if_pend = 1'b1;
    if_addr = a;
  endtask

  task automatic issue_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    dm_pend  = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
  endtask

  task automatic reset_model();
    ph = PH_IDLE; who = 0; streak = 0;
    if_pend = 1'b0; dm_pend = 1'b0; if_rep = 1'b0; dm_rep = 1'b0; auto_on = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    if_hold = '0; dm_hold = '0; prev_mem_req = 1'b0; fixed_wait = -1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mem_req"}, mem_req, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
    chk({pfx, "_if_ack"}, if_ack, 0);
    chk({pfx, "_dm_ack"}, dm_ack, 0);
    chk({pfx, "_if_rdata"}, if_rdata, 0);
    chk({pfx, "_dm_rdata"}, dm_rdata, 0);
  endtask

  // One clock of the model: check registered outputs, drive requesters and memory,
  // predict the next phase, then check the combinational stalls.
  task automatic tick();
    ph_t nph;
    bit  ready, ack_if, ack_dm, pick_if;
    @(posedge clk);
    #1;
    cyc++;
    nph    = ph;
    ack_if = (ph == PH_RESP) && (who == 1);
    ack_dm = (ph == PH_RESP) && (who == 2);
    if (ack_if) if_hold = resp_data;
    if (ack_dm && !x_we) dm_hold = resp_data;

    chk("mem_req", mem_req, ph == PH_BUSY);
    chk("if_ack", if_ack, ack_if);
    chk("dm_ack", dm_ack, ack_dm);
    chk("if_rdata", if_rdata, if_hold);
    chk("dm_rdata", dm_rdata, dm_hold);
    if (ph == PH_BUSY) begin
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_we", mem_we, x_we);
      if (x_we) chk("mem_wdata", mem_wdata, x_wdata);
    end
    if (mem_req === 1'b1) begin
      mreq_cnt++;
      obs_we    = mem_we;
      obs_wdata = mem_wdata;
      if (prev_mem_req !== 1'b1) grant_log.push_back(mem_addr);
    end
    prev_mem_req = mem_req;
    if (if_ack === 1'b1) if_ack_cyc = cyc;
    if (dm_ack === 1'b1) dm_ack_cyc = cyc;

    if (ack_if) begin
      if_pend = 1'b0;
      if (if_rep) issue_if(if_addr + 32'd4);
    end
    if (ack_dm) begin
      dm_pend = 1'b0;
      if (dm_rep) issue_dm(1'b0, dm_addr + 32'd4, 32'h0);
    end
    if (auto_on) begin
      if (!if_pend && ($urandom_range(0, 1) == 1)) issue_if(32'($urandom_range(0, 255)) << 2);
      if (!dm_pend && ($urandom_range(0, 1) == 1))
        issue_dm(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 63)) << 2), $urandom);
    end
    if_req = if_pend;
    dm_req = dm_pend;

    ready = 1'b0;
    if (ph == PH_BUSY) begin
      ready = (wait_left == 0);
      if (!ready) wait_left--;
    end
    mem_ready = ready;
    mem_rdata = ready ? mem_val(x_addr) : $urandom;
    if (ready) ready_cyc = cyc;

    case (ph)
      PH_IDLE: begin
        if (if_req || dm_req) begin
          pick_if = if_req && (!dm_req || (streak == SMAX));
          if (pick_if) begin
            who = 1; x_addr = if_addr; x_we = 1'b0; streak = 0;
          end else begin
            who = 2; x_addr = dm_addr; x_we = dm_we; x_wdata = dm_wdata;
            streak = if_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
          end
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          nph = PH_BUSY;
        end
      end
      PH_BUSY: begin
        if (ready) begin
          resp_data = mem_val(x_addr);
          if (x_we) mem_img[x_addr] = x_wdata;
          nph = PH_RESP;
        end
      end
      default: nph = PH_IDLE;
    endcase

    #1;
    chk("if_stall", if_stall, if_req && !ack_if);
    chk("dm_stall", dm_stall, dm_req && !ack_dm);
    if (if_stall === 1'b1) if_stall_cnt++;
    ph = nph;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((if_pend || dm_pend || ph != PH_IDLE) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", n >= budget, 0);
  endtask

  initial begin
    int start;
    logic [31:0] ld_val;

    rst_n = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk_all_zero("reset");

    // Lone fetch, zero wait states.
    mem_img[32'h40] = 32'h00500093;
    fixed_wait = 0; if_stall_cnt = 0; mreq_cnt = 0;
    start = cyc;
    issue_if(32'h40);
    drain(20);
    chk("fetch_cycles", cyc - start, 3);
    chk("fetch_stall_cycles", if_stall_cnt, 2);
    chk("fetch_busy_cycles", mreq_cnt, 1);
    chk("fetch_rdata", if_rdata, 32'h00500093);

    // Collision: DM first, then IF.
    fixed_wait = -1;
    grant_log.delete();
    if_ack_cyc = -1; dm_ack_cyc = -1;
    issue_if(32'h1000);
    issue_dm(1'b0, 32'h100, 32'h0);
    drain(40);
    chk("collision_grants", grant_log.size(), 2);
    chk("collision_first", grant_log[0], 32'h100);
    chk("collision_second", grant_log[1], 32'h1000);
    chk("collision_order", (dm_ack_cyc > 0) && (dm_ack_cyc < if_ack_cyc), 1);
    ld_val = mem_val(32'h100);
    chk("collision_dm_rdata", dm_rdata, ld_val);

    // Store leaves dm_rdata alone.
    issue_dm(1'b1, 32'h200, 32'hDEADBEEF);
    drain(20);
    chk("store_mem_we", obs_we, 1);
    chk("store_mem_wdata", obs_wdata, 32'hDEADBEEF);
    chk("store_dm_rdata", dm_rdata, ld_val);

    // Starvation: both held, pattern DM x4 then IF.
    fixed_wait = 0;
    grant_log.delete();
    if_rep = 1'b1; dm_rep = 1'b1;
    issue_if(32'h1000);
    issue_dm(1'b0, 32'h2000, 32'h0);
    repeat (60) tick();
    if_rep = 1'b0; dm_rep = 1'b0;
    drain(40);
    chk("starve_grant_count", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      chk($sformatf("starve_grant%0d_is_dm", i), grant_log[i][13], (i % 5) != 4);
    end

    // Five wait states.
    fixed_wait = 5; mreq_cnt = 0; dm_ack_cyc = -1; ready_cyc = -100;
    issue_dm(1'b0, 32'h300, 32'h0);
    drain(30);
    chk("wait_busy_cycles", mreq_cnt, 6);
    chk("wait_ack_latency", dm_ack_cyc - ready_cyc, 1);

    // Randomized traffic.
    fixed_wait = -1;
    auto_on = 1'b1;
    repeat (400) tick();
    auto_on = 1'b0;
    drain(80);

    // Reset in the middle of a DM access.
    fixed_wait = 20;
    issue_dm(1'b0, 32'h400, 32'h0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_dm_ack", dm_ack, 0);
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk_all_zero("post_reset");
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
